readout_serial_scheduler: RTL and testbench
===========================================

// Module: readout_serial_scheduler
// PURPOSE
//  Round-robin scheduler that shares one output_parallel_to_serial lane between NUM_REQ readout sources.
//  Arbitrates requests and loads the winner's WIDTH_INPUT-bit word into the serializer.
//  Times the shift window and the inter-frame gap, and reports frame boundaries and source ID.
//  Sits between the row/readout buffers and the serializer feeding the output pad.
// PARAMETERS
//  WIDTH_INPUT  128  bits per frame; must match the serializer's WIDTH_INPUT
//  NUM_REQ      4    number of requesters, >=1
//  GAP_CYCLES   2    idle cycles after each shift window, >=0
//  (local) ID_W = (NUM_REQ>1) ? $clog2(NUM_REQ) : 1;  CNT_W = $clog2(WIDTH_INPUT)
// PORTS
//  CLK          in   1                    system clock, rising edge
//  RST          in   1                    synchronous reset, active-high
//  en           in   1                    enables new arbitration; a frame in progress always completes
//  req          in   NUM_REQ              per-source request; held high until that source's grant
//  req_data     in   NUM_REQ*WIDTH_INPUT  source k occupies bits [k*W +: W]; stable while req[k]=1
//  grant        out  NUM_REQ              one-hot, 1-cycle pulse: word accepted, source may drop req
//  ser_load     out  1                    1-cycle pulse: serializer captures ser_data
//  ser_data     out  WIDTH_INPUT          registered word to serializer; holds until next load
//  ser_valid    out  1                    high for exactly WIDTH_INPUT cycles while bits shift out
//  frame_start  out  1                    pulse, coincident with ser_load
//  frame_id     out  ID_W                 source of current/last frame; updated at LOAD
//  busy         out  1                    state != IDLE
//  parity_bit   out  1                    exists only with READOUT_PARITY_EN
//  parity_valid out  1                    exists only with READOUT_PARITY_EN
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, bit_cnt=0, gap_cnt=0; every output 0, ser_data included.
//  RST asserted in any state: on the next edge, return to reset values. The frame is dropped and no grant is issued.
//  FSM states: IDLE -> LOAD -> SHIFT -> [PARITY] -> GAP -> IDLE.
//  IDLE: if en && |req, register winner = first set req[i], searching i = rr_ptr, rr_ptr+1, ... with wrap; go to LOAD.
//        Otherwise stay in IDLE.
//  LOAD (1 cycle): grant[winner]=1, ser_load=1, frame_start=1.
//        ser_data <= req_data[winner]; frame_id <= winner.
//        rr_ptr <= (winner==NUM_REQ-1) ? 0 : winner+1; bit_cnt <= 0; go to SHIFT.
//  SHIFT: ser_valid=1; bit_cnt increments each cycle. At bit_cnt==WIDTH_INPUT-1, go to PARITY if enabled, else GAP.
//  GAP: GAP_CYCLES cycles with ser_valid=0, then IDLE. GAP_CYCLES=0 skips GAP entirely.
//  Frame period with continuous requests = 2 + WIDTH_INPUT + GAP_CYCLES cycles (132 at defaults).
//  The serializer emits MSB-first, one bit per cycle, starting the cycle after ser_load.
//  ser_valid marks exactly those cycles.
//  en: sampled only in IDLE. Dropping en mid-frame does not shorten SHIFT, PARITY or GAP.
//  req dropping between IDLE and LOAD: grant is still issued to the latched winner, and the data is loaded as sampled.
//  Simultaneous requests: strict rotation. No source waits more than NUM_REQ-1 frames.
//  NUM_REQ=1: rr_ptr stays 0, frame_id=0.
//  grant, ser_load and frame_start are never high outside LOAD.
// CONFIGURATION
//  READOUT_PARITY_EN defined:
//   - Adds the PARITY state (1 cycle) after SHIFT: ser_valid=0, parity_valid=1, parity_bit = ^ser_data (even parity).
//   - parity_bit holds its value until the next LOAD; reset value 0.
//   - Frame period becomes 3 + WIDTH_INPUT + GAP_CYCLES.
//  READOUT_PARITY_EN undefined: no PARITY state; parity_bit and parity_valid ports are absent.
// TESTING
//  1. RST=1 for 5 cycles with req=4'b1111 -> grant=0, ser_load=0, ser_valid=0, busy=0, ser_data=0 throughout.
//  2. en=1, req=4'b0010, req_data[1]=128'hA5A5...A5:
//     - one grant[1] pulse, concurrent with ser_load and frame_start; frame_id=1; ser_data=A5..A5.
//     - ser_valid high for exactly 128 cycles, then 2 low cycles; busy falls after 131 cycles.
//     - the serial output matches A5..A5 MSB-first.
//  3. req=4'b1111 held, each source re-raising req after its grant -> grant order 0,1,2,3,0,1;
//     frame_start pulses spaced exactly 132 cycles apart.
//  4. en=0 with req=4'b0100 for 300 cycles -> no grant. Then set en=1 -> grant[2] within 2 cycles.
//     Clear en at bit 10 of SHIFT -> ser_valid still spans 128 cycles.
//  5. RST pulsed at bit_cnt=40 during a frame from source 2:
//     - next cycle: ser_valid=0, busy=0, all outputs 0.
//     - with req=4'b1111, the next grant goes to source 0.
//  6. READOUT_PARITY_EN build:
//     - data=128'hA5..A5 -> parity_valid pulse the cycle after the last ser_valid, parity_bit=0.
//     - data=128'h1 -> parity_bit=1; frame period 133.

Source files
------------

// File: rtl/readout_serial_scheduler.sv
// Round-robin scheduler sharing one parallel-to-serial lane between NUM_REQ readout sources.
// Optional feature macro: READOUT_PARITY_EN adds a one-cycle even-parity state after each shift window.
module readout_serial_scheduler #(
    parameter int WIDTH_INPUT = 128,
    parameter int NUM_REQ     = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                                          CLK,
    input  logic                                          RST,
    input  logic                                          en,
    input  logic [NUM_REQ-1:0]                            req,
    input  logic [NUM_REQ*WIDTH_INPUT-1:0]                req_data,
    output logic [NUM_REQ-1:0]                            grant,
    output logic                                          ser_load,
    output logic [WIDTH_INPUT-1:0]                        ser_data,
    output logic                                          ser_valid,
    output logic                                          frame_start,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] frame_id,
    output logic                                          busy
`ifdef READOUT_PARITY_EN
    ,
    output logic                                          parity_bit,
    output logic                                          parity_valid
`endif
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (WIDTH_INPUT > 1) ? $clog2(WIDTH_INPUT) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
`ifdef READOUT_PARITY_EN
        S_PARITY,
`endif
        S_GAP
    } state_t;

    // With no gap configured the frame returns straight to IDLE after the data phase.
    localparam state_t POST_SHIFT = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;

    state_t                   state_q;
    logic [ID_W-1:0]          rr_ptr_q;
    logic [CNT_W-1:0]         bit_cnt_q;
    logic [GAP_W-1:0]         gap_cnt_q;
    logic [NUM_REQ-1:0]       grant_q;
    logic                     ser_load_q;
    logic [WIDTH_INPUT-1:0]   ser_data_q;
    logic                     ser_valid_q;
    logic                     frame_start_q;
    logic [ID_W-1:0]          frame_id_q;
    logic                     busy_q;
`ifdef READOUT_PARITY_EN
    logic                     parity_bit_q;
    logic                     parity_valid_q;
`endif

    logic [2*NUM_REQ-1:0]     req_double_d;
    logic [NUM_REQ-1:0]       req_rot_d;
    logic [ID_W-1:0]          offset_d;
    logic [ID_W:0]            sum_d;
    logic [ID_W-1:0]          winner_d;
    logic [ID_W-1:0]          rr_next_d;
    logic [WIDTH_INPUT-1:0]   sel_data_d;

    // Rotate requests so bit 0 is the source at rr_ptr, take the lowest set bit, then rotate back.
    always_comb begin
        req_double_d = {req, req} >> rr_ptr_q;
        req_rot_d    = req_double_d[NUM_REQ-1:0];
        offset_d     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot_d[i]) begin
                offset_d = ID_W'(i);
            end
        end
        sum_d = {1'b0, rr_ptr_q} + {1'b0, offset_d};
        if (sum_d >= (ID_W + 1)'(NUM_REQ)) begin
            sum_d = sum_d - (ID_W + 1)'(NUM_REQ);
        end
        winner_d  = sum_d[ID_W-1:0];
        rr_next_d = (winner_d == ID_W'(NUM_REQ - 1)) ? '0 : winner_d + 1'b1;
        sel_data_d = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (winner_d == ID_W'(k)) begin
                sel_data_d = req_data[k*WIDTH_INPUT +: WIDTH_INPUT];
            end
        end
    end

    // Outputs are registered one state ahead so they are valid during the state they describe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= S_IDLE;
            rr_ptr_q       <= '0;
            bit_cnt_q      <= '0;
            gap_cnt_q      <= '0;
            grant_q        <= '0;
            ser_load_q     <= 1'b0;
            ser_data_q     <= '0;
            ser_valid_q    <= 1'b0;
            frame_start_q  <= 1'b0;
            frame_id_q     <= '0;
            busy_q         <= 1'b0;
`ifdef READOUT_PARITY_EN
            parity_bit_q   <= 1'b0;
            parity_valid_q <= 1'b0;
`endif
        end else begin
            grant_q       <= '0;
            ser_load_q    <= 1'b0;
            frame_start_q <= 1'b0;
`ifdef READOUT_PARITY_EN
            parity_valid_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (en && |req) begin
                        state_q       <= S_LOAD;
                        grant_q       <= NUM_REQ'(1) << winner_d;
                        ser_load_q    <= 1'b1;
                        frame_start_q <= 1'b1;
                        ser_data_q    <= sel_data_d;
                        frame_id_q    <= winner_d;
                        rr_ptr_q      <= rr_next_d;
                        busy_q        <= 1'b1;
                    end
                end
                S_LOAD: begin
                    state_q     <= S_SHIFT;
                    ser_valid_q <= 1'b1;
                    bit_cnt_q   <= '0;
                end
                S_SHIFT: begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CNT_W'(WIDTH_INPUT - 1)) begin
                        ser_valid_q <= 1'b0;
`ifdef READOUT_PARITY_EN
                        state_q        <= S_PARITY;
                        parity_valid_q <= 1'b1;
                        parity_bit_q   <= ^ser_data_q;
`else
                        state_q   <= POST_SHIFT;
                        busy_q    <= (GAP_CYCLES > 0);
                        gap_cnt_q <= '0;
`endif
                    end
                end
`ifdef READOUT_PARITY_EN
                S_PARITY: begin
                    state_q   <= POST_SHIFT;
                    busy_q    <= (GAP_CYCLES > 0);
                    gap_cnt_q <= '0;
                end
`endif
                S_GAP: begin
                    if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign ser_load    = ser_load_q;
    assign ser_data    = ser_data_q;
    assign ser_valid   = ser_valid_q;
    assign frame_start = frame_start_q;
    assign frame_id    = frame_id_q;
    assign busy        = busy_q;
`ifdef READOUT_PARITY_EN
    assign parity_bit   = parity_bit_q;
    assign parity_valid = parity_valid_q;
`endif

endmodule

// File: tb/tb_readout_serial_scheduler.sv
// Self-checking bench for readout_serial_scheduler: randomized requests against a round-robin reference model.
// Parity checks are compiled in when READOUT_PARITY_EN is defined.
module tb_readout_serial_scheduler;

    localparam int W   = 128;
    localparam int N   = 4;
    localparam int GAP = 2;
`ifdef READOUT_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int BUSY_LEN = 1 + W + PAR + GAP;
    localparam int PERIOD   = 2 + W + PAR + GAP;

    logic           CLK = 1'b0;
    logic           RST;
    logic           en;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   grant;
    logic           ser_load;
    logic [W-1:0]   ser_data;
    logic           ser_valid;
    logic           frame_start;
    logic [1:0]     frame_id;
    logic           busy;
`ifdef READOUT_PARITY_EN
    logic           parity_bit;
    logic           parity_valid;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int modelPtr = 0;

    logic parSeen;
    logic parBit;
    logic parRightAfter;

    readout_serial_scheduler #(.WIDTH_INPUT(W), .NUM_REQ(N), .GAP_CYCLES(GAP)) dut (
        .CLK(CLK),
        .RST(RST),
        .en(en),
        .req(req),
        .req_data(req_data),
        .grant(grant),
        .ser_load(ser_load),
        .ser_data(ser_data),
        .ser_valid(ser_valid),
        .frame_start(frame_start),
        .frame_id(frame_id),
        .busy(busy)
`ifdef READOUT_PARITY_EN
        ,
        .parity_bit(parity_bit),
        .parity_valid(parity_valid)
`endif
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    // Reference round-robin: first requester at or after the pointer, with wrap.
    function automatic int rrPick(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] randWord();
        logic [W-1:0] w;
        for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic applyReset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        modelPtr = 0;
    endtask

    task automatic waitGrant(output int waited);
        waited = 0;
        while (grant === '0 && waited < 20) begin
            tick();
            waited++;
        end
    endtask

    // Models the serializer: capture on ser_load, shift MSB first while ser_valid.
    task automatic observeFrame(output int busyCycles, output int validCycles,
                                output int gapCycles, output logic [W-1:0] rx);
        logic [W-1:0] sh;
        busyCycles = 0; validCycles = 0; gapCycles = 0; rx = '0; sh = '0;
        parSeen = 1'b0; parBit = 1'b0; parRightAfter = 1'b0;
        while (busy === 1'b1 && busyCycles < 1000) begin
            if (ser_load === 1'b1) sh = ser_data;
            if (ser_valid === 1'b1) begin
                rx = {rx[W-2:0], sh[W-1]};
                sh = sh << 1;
                validCycles++;
            end else if (validCycles > 0) begin
`ifdef READOUT_PARITY_EN
                if (parity_valid === 1'b1) begin
                    parSeen = 1'b1;
                    parBit = parity_bit;
                    parRightAfter = (gapCycles == 0);
                end
`endif
                gapCycles++;
            end
            busyCycles++;
            tick();
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; en = 1'b1; req = '1;
        req_data = {randWord(), randWord(), randWord(), randWord()};
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if ({grant, ser_load, ser_valid, busy, frame_start} !== '0 || ser_data !== '0 || frame_id !== 2'd0) begin
                fails++;
                $display("[TB] FAIL reset_outputs cycle %0d: got grant=%b load=%b valid=%b busy=%b data=%h, required all zero",
                         i, grant, ser_load, ser_valid, busy, ser_data);
            end
        end
        req = '0;
        RST = 1'b0;
        modelPtr = 0;
        tick();
    endtask

    task automatic test_single_frame();
        logic [W-1:0] data;
        logic [W-1:0] rx;
        int waited, bc, vc, gc;
        data = {16{8'hA5}};
        req_data = {randWord(), randWord(), data, randWord()};
        en = 1'b1;
        req = 4'b0010;
        waitGrant(waited);
        tests++;
        if (grant !== 4'b0010 || ser_load !== 1'b1 || frame_start !== 1'b1) begin
            fails++;
            $display("[TB] FAIL single_grant: got grant=%b load=%b start=%b, required 0010 1 1", grant, ser_load, frame_start);
        end
        tests++;
        if (frame_id !== 2'd1 || ser_data !== data) begin
            fails++;
            $display("[TB] FAIL single_load: got id=%0d data=%h, required id=1 data=%h", frame_id, ser_data, data);
        end
        req = '0;
        observeFrame(bc, vc, gc, rx);
        modelPtr = 2;
        tests++;
        if (vc !== W || gc !== GAP + PAR) begin
            fails++;
            $display("[TB] FAIL single_window: got valid=%0d gap=%0d, required %0d %0d", vc, gc, W, GAP + PAR);
        end
        tests++;
        if (bc !== BUSY_LEN) begin
            fails++;
            $display("[TB] FAIL single_busy: got %0d busy cycles, required %0d", bc, BUSY_LEN);
        end
        tests++;
        if (rx !== data) begin
            fails++;
            $display("[TB] FAIL single_serial: got %h, required %h", rx, data);
        end
`ifdef READOUT_PARITY_EN
        tests++;
        if (parSeen !== 1'b1 || parRightAfter !== 1'b1 || parBit !== 1'b0) begin
            fails++;
            $display("[TB] FAIL single_parity: got seen=%b after=%b bit=%b, required 1 1 0", parSeen, parRightAfter, parBit);
        end
`endif
    endtask

    task automatic test_round_robin();
        logic [W-1:0] rx;
        int waited, bc, vc, gc, exp, lastCyc;
        applyReset();
        req_data = {randWord(), randWord(), randWord(), randWord()};
        en = 1'b1;
        req = 4'b1111;
        lastCyc = 0;
        for (int f = 0; f < 6; f++) begin
            waitGrant(waited);
            exp = rrPick(req, modelPtr);
            tests++;
            if (grant !== N'(1 << exp) || frame_id !== 2'(exp)) begin
                fails++;
                $display("[TB] FAIL rr_order frame %0d: got grant=%b id=%0d, required source %0d", f, grant, frame_id, exp);
            end
            if (f > 0) begin
                tests++;
                if (cyc - lastCyc !== PERIOD) begin
                    fails++;
                    $display("[TB] FAIL rr_period frame %0d: got %0d cycles, required %0d", f, cyc - lastCyc, PERIOD);
                end
            end
            lastCyc = cyc;
            modelPtr = (exp + 1) % N;
            observeFrame(bc, vc, gc, rx);
        end
        req = '0;
        tick();
    endtask

    task automatic test_enable();
        logic [W-1:0] rx;
        int waited, seen, vc, guard;
        en = 1'b0;
        req = 4'b0100;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (grant !== '0 || busy !== 1'b0) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("[TB] FAIL enable_hold: got %0d active cycles with en=0, required 0", seen);
        end
        en = 1'b1;
        waitGrant(waited);
        tests++;
        if (grant !== 4'b0100 || waited > 2) begin
            fails++;
            $display("[TB] FAIL enable_grant: got grant=%b after %0d cycles, required 0100 within 2", grant, waited);
        end
        modelPtr = 3;
        req = '0;
        vc = 0;
        guard = 0;
        while (busy === 1'b1 && guard < 1000) begin
            if (ser_valid === 1'b1) begin
                vc++;
                if (vc == 11) en = 1'b0;
            end
            guard++;
            tick();
        end
        tests++;
        if (vc !== W) begin
            fails++;
            $display("[TB] FAIL enable_drop: got %0d valid cycles, required %0d", vc, W);
        end
        en = 1'b1;
        rx = '0;
    endtask

    task automatic test_reset_midframe();
        logic [W-1:0] rx;
        int waited, vc, guard, bc, gc;
        req_data = {randWord(), randWord(), randWord(), randWord()};
        en = 1'b1;
        req = 4'b0100;
        waitGrant(waited);
        tests++;
        if (grant !== 4'b0100) begin
            fails++;
            $display("[TB] FAIL midreset_grant: got %b, required 0100", grant);
        end
        req = '0;
        vc = 0;
        guard = 0;
        while (vc < 41 && guard < 1000) begin
            tick();
            guard++;
            if (ser_valid === 1'b1) vc++;
        end
        RST = 1'b1;
        tick();
        tests++;
        if ({grant, ser_load, ser_valid, busy, frame_start} !== '0 || ser_data !== '0 || frame_id !== 2'd0) begin
            fails++;
            $display("[TB] FAIL midreset_clear: got grant=%b valid=%b busy=%b data=%h id=%0d, required all zero",
                     grant, ser_valid, busy, ser_data, frame_id);
        end
        RST = 1'b0;
        modelPtr = 0;
        req = 4'b1111;
        waitGrant(waited);
        tests++;
        if (grant !== 4'b0001) begin
            fails++;
            $display("[TB] FAIL midreset_next: got grant=%b, required 0001", grant);
        end
        modelPtr = 1;
        req = '0;
        observeFrame(bc, vc, gc, rx);
    endtask

    task automatic test_random();
        logic [W-1:0] words [N];
        logic [W-1:0] rx;
        logic [N-1:0] mask;
        int waited, bc, vc, gc, exp;
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < N; k++) words[k] = randWord();
            if (f == 0) words[0] = W'(1);
            for (int k = 0; k < N; k++) req_data[k*W +: W] = words[k];
            mask = N'($urandom_range(1, (1 << N) - 1));
            if (f == 0) mask = N'(1);
            exp = rrPick(mask, modelPtr);
            en = 1'b1;
            req = mask;
            waitGrant(waited);
            tests++;
            if (grant !== N'(1 << exp) || frame_id !== 2'(exp) || ser_data !== words[exp]) begin
                fails++;
                $display("[TB] FAIL random_load frame %0d: got grant=%b id=%0d data=%h, required source %0d data=%h",
                         f, grant, frame_id, ser_data, exp, words[exp]);
            end
            modelPtr = (exp + 1) % N;
            req = '0;
            observeFrame(bc, vc, gc, rx);
            tests++;
            if (rx !== words[exp] || bc !== BUSY_LEN) begin
                fails++;
                $display("[TB] FAIL random_serial frame %0d: got %h busy=%0d, required %h busy=%0d",
                         f, rx, bc, words[exp], BUSY_LEN);
            end
`ifdef READOUT_PARITY_EN
            tests++;
            if (parSeen !== 1'b1 || parBit !== ^words[exp]) begin
                fails++;
                $display("[TB] FAIL random_parity frame %0d: got seen=%b bit=%b, required 1 %b",
                         f, parSeen, parBit, ^words[exp]);
            end
`endif
            for (int d = 0; d < int'($urandom_range(0, 3)); d++) tick();
        end
    endtask

    initial begin
        RST = 1'b1;
        en = 1'b0;
        req = '0;
        req_data = '0;
        test_reset();
        test_single_frame();
        test_round_robin();
        test_enable();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
